// File: rtl/uart_bus_master_pkg.sv
// Shared types and constants for the UART-to-PicoRV32 bus master.
// The TX parser state exists only when UART_BUS_MASTER_READ_EN is defined.
package uart_bus_master_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS
`ifdef UART_BUS_MASTER_READ_EN
    , ST_TX
`endif
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

endpackage

// File: rtl/uart_bus_master_if.sv
// PicoRV32-native memory bus between the UART bus master and a responder.
interface uart_bus_master_if;
  logic        mem_valid_o;
  logic        mem_instr_o;
  logic        mem_ready_in;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_in;

  modport master (
    output mem_valid_o, mem_instr_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ready_in, mem_rdata_in
  );

  modport slave (
    input  mem_valid_o, mem_instr_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_ready_in, mem_rdata_in
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte
// valid pulse and one-cycle framing-error pulse.
module uart_rx
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync_meta;
  logic             sync_q;
  logic             sync_prev;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta    <= 1'b1;
      sync_q       <= 1'b1;
      sync_prev    <= 1'b1;
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync_meta    <= serial_in;
      sync_q       <= sync_meta;
      sync_prev    <= sync_q;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (sync_prev && !sync_q) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at half-bit was a glitch.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {sync_q, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (sync_q) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART command parser driving a PicoRV32-native bus: 'W' addr[4] data[4] writes.
// Define UART_BUS_MASTER_READ_EN to add 'R' addr[4] reads echoed back on serial_o.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        cpu_clk_in,
  input  logic        resetn_in,
  input  logic        serial_in,
  output logic        serial_o,
  output logic        busy_o,
  uart_bus_master_if.master bus
);

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_frame_err;
  parser_state_t state;
  bus_req_t      req;
  logic [1:0]    byte_cnt;
  logic          valid_q;
  logic          busy_q;
  logic          is_read;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (cpu_clk_in),
    .rst_n        (resetn_in),
    .serial_in    (serial_in),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  assign bus.mem_valid_o = valid_q;
  assign bus.mem_instr_o = 1'b0;
  assign bus.mem_addr_o  = req.addr;
  assign bus.mem_wdata_o = req.wdata;
  assign bus.mem_wstrb_o = req.wstrb;
  assign busy_o          = busy_q;

`ifdef UART_BUS_MASTER_READ_EN
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             serial_q;
  logic [31:0]      tx_word;
  logic [8:0]       tx_frame;
  logic [3:0]       tx_bits_left;
  logic [1:0]       tx_bytes_left;
  logic [CNT_W-1:0] tx_cnt;

  assign serial_o = serial_q;
`else
  logic unused_rdata;

  assign unused_rdata = ^bus.mem_rdata_in;
  assign serial_o     = 1'b1;
`endif

  always_ff @(posedge cpu_clk_in) begin
    if (!resetn_in) begin
      state    <= ST_IDLE;
      req      <= '0;
      byte_cnt <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      is_read  <= 1'b0;
`ifdef UART_BUS_MASTER_READ_EN
      serial_q      <= 1'b1;
      tx_word       <= '0;
      tx_frame      <= '0;
      tx_bits_left  <= '0;
      tx_bytes_left <= '0;
      tx_cnt        <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            byte_cnt <= '0;
            if (rx_byte == CMD_WRITE) begin
              state   <= ST_ADDR;
              is_read <= 1'b0;
              busy_q  <= 1'b1;
            end
`ifdef UART_BUS_MASTER_READ_EN
            else if (rx_byte == CMD_READ) begin
              state   <= ST_ADDR;
              is_read <= 1'b1;
              busy_q  <= 1'b1;
            end
`endif
          end
        end
        ST_ADDR: begin
          if (rx_frame_err) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (rx_valid) begin
            req.addr[{byte_cnt, 3'b000} +: 8] <= rx_byte;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_read) begin
                state     <= ST_BUS;
                valid_q   <= 1'b1;
                req.wstrb <= 4'h0;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (rx_frame_err) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (rx_valid) begin
            req.wdata[{byte_cnt, 3'b000} +: 8] <= rx_byte;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state     <= ST_BUS;
              valid_q   <= 1'b1;
              req.wstrb <= 4'hF;
            end
          end
        end
        ST_BUS: begin
          // Incoming bytes are dropped here; the receiver keeps framing.
          if (bus.mem_ready_in) begin
            valid_q   <= 1'b0;
            req.wstrb <= 4'h0;
`ifdef UART_BUS_MASTER_READ_EN
            if (is_read) begin
              state         <= ST_TX;
              tx_word       <= bus.mem_rdata_in;
              tx_frame      <= {1'b1, bus.mem_rdata_in[7:0]};
              tx_bits_left  <= 4'd9;
              tx_bytes_left <= 2'd3;
              tx_cnt        <= '0;
              serial_q      <= 1'b0;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
`else
            state  <= ST_IDLE;
            busy_q <= 1'b0;
`endif
          end
        end
`ifdef UART_BUS_MASTER_READ_EN
        ST_TX: begin
          // tx_frame holds the remaining data+stop bits of the current byte.
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bits_left == 4'd0) begin
              if (tx_bytes_left == 2'd0) begin
                state    <= ST_IDLE;
                busy_q   <= 1'b0;
                serial_q <= 1'b1;
              end else begin
                tx_bytes_left <= tx_bytes_left - 2'd1;
                tx_word       <= {8'h00, tx_word[31:8]};
                tx_frame      <= {1'b1, tx_word[15:8]};
                tx_bits_left  <= 4'd9;
                serial_q      <= 1'b0;
              end
            end else begin
              serial_q     <= tx_frame[0];
              tx_frame     <= {1'b0, tx_frame[8:1]};
              tx_bits_left <= tx_bits_left - 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with bus and UART scoreboards.
module tb_uart_bus_master;
  import uart_bus_master_pkg::*;

  localparam int unsigned CB = 16;

  logic clk       = 1'b0;
  logic resetn    = 1'b0;
  logic serial_in = 1'b1;
  logic serial_o;
  logic busy;

  uart_bus_master_if bus ();

  uart_bus_master #(.CLKS_PER_BIT(CB)) dut (
    .cpu_clk_in (clk),
    .resetn_in  (resetn),
    .serial_in  (serial_in),
    .serial_o   (serial_o),
    .busy_o     (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          bus_count = 0;
  int          tx_count = 0;
  int          ready_delay = 0;
  bit          hold_ready = 1'b0;
  bit          serial_low_seen = 1'b0;
  logic [31:0] rd_value = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  bus_req_t    exp_q[$];
  logic [7:0]  exp_tx_q[$];
  bus_req_t    got;
  bus_req_t    e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    repeat (CB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CB) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (CB) @(negedge clk);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] addr, input logic [31:0] wdata);
    bus_req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstrb = 4'hF;
    exp_q.push_back(r);
    send_byte(CMD_WRITE, 1'b1);
    check("busy_after_cmd", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8], 1'b1);
    last_wdata = wdata;
  endtask

  task automatic wait_bus(input int target);
    for (int i = 0; i < 3000 && bus_count < target; i++) @(negedge clk);
    check("bus_done", bus_count, target);
  endtask

  // Bus responder: pops the expected request, holds ready off, then strobes it.
  initial begin
    bus.mem_ready_in = 1'b0;
    bus.mem_rdata_in = 32'h0;
    forever begin
      @(negedge clk);
      if (resetn && bus.mem_valid_o === 1'b1) begin
        got.addr  = bus.mem_addr_o;
        got.wdata = bus.mem_wdata_o;
        got.wstrb = bus.mem_wstrb_o;
        if (exp_q.size() == 0) begin
          check("unexpected_bus_cycle", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("bus_addr", got.addr, e.addr);
          check("bus_wdata", got.wdata, e.wdata);
          check("bus_wstrb", 32'(got.wstrb), 32'(e.wstrb));
          check("bus_instr", 32'(bus.mem_instr_o), 32'd0);
        end
        if (hold_ready) begin
          for (int i = 0; i < 2000 && bus.mem_valid_o === 1'b1; i++) @(negedge clk);
          check("valid_abandoned", 32'(bus.mem_valid_o), 32'd0);
        end else begin
          for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            check("valid_held", 32'(bus.mem_valid_o), 32'd1);
            check("addr_stable", bus.mem_addr_o, got.addr);
          end
          bus.mem_ready_in = 1'b1;
          bus.mem_rdata_in = rd_value;
          @(negedge clk);
          bus.mem_ready_in = 1'b0;
          check("valid_drop", 32'(bus.mem_valid_o), 32'd0);
          bus_count++;
        end
      end
    end
  end

  // UART monitor on serial_o: decodes 8N1 bytes and compares to expected queue.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (serial_o !== 1'b1) serial_low_seen = 1'b1;
      if (resetn && serial_o === 1'b0) begin
        repeat (CB / 2) @(negedge clk);
        check("tx_start", 32'(serial_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CB) @(negedge clk);
          b[i] = serial_o;
        end
        repeat (CB) @(negedge clk);
        check("tx_stop", 32'(serial_o), 32'd1);
        if (exp_tx_q.size() == 0) check("unexpected_tx_byte", 32'(b), 32'hFFFF);
        else check("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
        tx_count++;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.mem_valid_o), 32'd0);
    check("rst_addr", bus.mem_addr_o, 32'd0);
    check("rst_wdata", bus.mem_wdata_o, 32'd0);
    check("rst_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
    check("rst_instr", 32'(bus.mem_instr_o), 32'd0);
    check("rst_serial", 32'(serial_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Basic write, ready three cycles after valid.
    ready_delay = 3;
    send_frame(32'h8000_0000, 32'hDEAD_BEEF);
    wait_bus(1);
    check("busy_after_write", 32'(busy), 32'd0);
    check("wstrb_idle", 32'(bus.mem_wstrb_o), 32'd0);
    check("addr_retained", bus.mem_addr_o, 32'h8000_0000);

    // Unknown byte ignored, then one write.
    send_byte(8'h41, 1'b1);
    check("busy_after_unknown", 32'(busy), 32'd0);
    check("count_after_unknown", bus_count, 1);
    ready_delay = 0;
    send_frame(32'h0000_0010, 32'h1122_3344);
    wait_bus(2);
    repeat (200) @(negedge clk);
    check("single_write", bus_count, 2);

    // Framing error in the third address byte abandons the command.
    send_byte(CMD_WRITE, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h99, 1'b0);
    repeat (4 * CB) @(negedge clk);
    check("busy_after_frame_err", 32'(busy), 32'd0);
    check("no_bus_after_frame_err", bus_count, 2);
    ready_delay = 1;
    send_frame(32'h0000_0020, 32'hCAFE_F00D);
    wait_bus(3);

    // Reset while the request is outstanding.
    hold_ready = 1'b1;
    send_frame(32'h0000_0030, 32'h0BAD_CAFE);
    check("valid_before_reset", 32'(bus.mem_valid_o), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("valid_after_reset", 32'(bus.mem_valid_o), 32'd0);
    check("busy_after_reset", 32'(busy), 32'd0);
    check("addr_after_reset", bus.mem_addr_o, 32'd0);
    resetn = 1'b1;
    hold_ready = 1'b0;
    repeat (5) @(negedge clk);
    ready_delay = 2;
    send_frame(32'h0000_0040, 32'h55AA_55AA);
    wait_bus(4);
    check("wdata_after_recovery", bus.mem_wdata_o, 32'h55AA_55AA);

    // Read command.
    rd_value = 32'h1234_5678;
`ifdef UART_BUS_MASTER_READ_EN
    begin
      bus_req_t r;
      r.addr  = 32'h0000_0010;
      r.wdata = last_wdata;
      r.wstrb = 4'h0;
      exp_q.push_back(r);
      exp_tx_q.push_back(8'h78);
      exp_tx_q.push_back(8'h56);
      exp_tx_q.push_back(8'h34);
      exp_tx_q.push_back(8'h12);
    end
`endif
    send_byte(CMD_READ, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
`ifdef UART_BUS_MASTER_READ_EN
    wait_bus(5);
    for (int i = 0; i < 3000 && tx_count < 4; i++) @(negedge clk);
    check("tx_bytes", tx_count, 4);
    repeat (2 * CB) @(negedge clk);
    check("busy_after_read", 32'(busy), 32'd0);
    check("serial_idle_after_read", 32'(serial_o), 32'd1);
`else
    repeat (300) @(negedge clk);
    check("no_bus_on_read", bus_count, 4);
    check("busy_read_disabled", 32'(busy), 32'd0);
    check("serial_idle_high", 32'(serial_low_seen), 32'd0);
    check("no_tx_bytes", tx_count, 0);
`endif
    check("bus_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
